// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, sequencer states
// and the request legality rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Unsigned widths exist only for loads; halves and words must be naturally aligned.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// load lane extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // Store side: enables and replicated data by access width.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {addr[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      2'b10: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted   = rdata >> {addr, 3'b000};
    rdata_ext = 32'h0000_0000;
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata_ext = shifted;
      F3_BU:   rdata_ext = {24'h00_0000, shifted[7:0]};
      F3_HU:   rdata_ext = {16'h0000, shifted[15:0]};
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer between the core datapath and a
// synchronous data memory port with fixed read latency.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wren,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [31:0] wdata_q;
  logic [2:0]  cnt;

  logic [2:0]  sel_f3;
  logic [1:0]  sel_lo;
  logic [31:0] sel_wdata;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        accept;
  logic        legal;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign legal  = is_legal(req_we, req_funct3, req_addr[1:0]);

  // Lane logic sees the live request while idle so ISSUE outputs can be registered at accept.
  always_comb begin
    if (state == IDLE) begin
      sel_f3    = req_funct3;
      sel_lo    = req_addr[1:0];
      sel_wdata = req_wdata;
    end else begin
      sel_f3    = f3_q;
      sel_lo    = lo_q;
      sel_wdata = wdata_q;
    end
  end

  lsu_lane_align u_align (
    .funct3    (sel_f3),
    .addr      (sel_lo),
    .wdata     (sel_wdata),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      lo_q       <= 2'b00;
      wdata_q    <= 32'h0000_0000;
      cnt        <= 3'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_fault <= 1'b0;
      mem_addr   <= '0;
      mem_wren   <= 1'b0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            lo_q      <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (legal) begin
              state     <= ISSUE;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= wdata_rep;
              mem_wren  <= req_we;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ISSUE: begin
          mem_wren <= 1'b0;
          cnt      <= 3'(MEM_LATENCY - 1);
          if (we_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= 32'h0000_0000;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= rdata_ext;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: one instance at MEM_LATENCY=1 and
// one at MEM_LATENCY=3, each behind a latency-accurate synchronous memory model.
module tb_load_store_unit;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_fault, a_mem_wren;
  logic [2:0]  a_req_funct3;
  logic [3:0]  a_mem_be;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_fault, b_mem_wren;
  logic [2:0]  b_req_funct3;
  logic [3:0]  b_mem_be;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  load_store_unit #(.MEM_LATENCY(1), .ADDR_WIDTH(32)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_fault(a_resp_fault),
    .mem_addr(a_mem_addr), .mem_wren(a_mem_wren), .mem_be(a_mem_be),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  load_store_unit #(.MEM_LATENCY(3), .ADDR_WIDTH(32)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_fault(b_resp_fault),
    .mem_addr(b_mem_addr), .mem_wren(b_mem_wren), .mem_be(b_mem_be),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Read-only memory image: a fixed word at 0x1000, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h12F4_5678;
    return (a * 32'h9E37_79B1) ^ 32'h7F4A_7C15;
  endfunction

  // Synchronous read ports: data reflects the address presented MEM_LATENCY cycles earlier.
  logic [31:0] a_pipe;
  logic [31:0] b_pipe [3];
  always @(posedge clk) begin
    a_pipe    <= a_mem_addr;
    b_pipe[0] <= b_mem_addr;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign a_mem_rdata = mem_word(a_pipe);
  assign b_mem_rdata = mem_word(b_pipe[2]);

  // Reference model, from the architectural rules.
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'b011 || f3[2:1] == 2'b11) return 1'b0;
    if (we && f3[2]) return 1'b0;
    return (addr % size_of(f3)) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << size_of(f3)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size_of(f3)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v, mask;
    int bits;
    v    = mem_word(addr & ~32'h3) >> (8 * (addr % 4));
    bits = 8 * size_of(f3);
    if (bits < 32) begin
      mask = (32'h1 << bits) - 32'h1;
      v    = v & mask;
      if (!f3[2] && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  logic [31:0] r_rdata, r_wdata, r_maddr;
  logic [3:0]  r_be;
  logic        r_fault;

  // One full transaction on the latency-1 instance, checked against the model.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] o_rdata,
                         output logic [3:0] o_be, output logic [31:0] o_wdata,
                         output logic [31:0] o_maddr, output logic o_fault);
    logic legal;
    logic [31:0] exp_rdata;
    int exp_k, resp_k, wren_n, wren_k;
    legal     = ref_legal(we, f3, addr);
    exp_k     = !legal ? 1 : (we ? 2 : 3);
    exp_rdata = (legal && !we) ? ref_load(f3, addr) : 32'h0;
    o_rdata = 32'h0; o_be = 4'h0; o_wdata = 32'h0; o_maddr = 32'h0; o_fault = 1'b0;
    resp_k = 0; wren_n = 0; wren_k = 0;
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1) $display("FAIL ready_before_req: got %b expected 1", a_req_ready);
    else passed++;
    a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0; a_req_we = $urandom % 2; a_req_funct3 = 3'($urandom);
    a_req_addr = $urandom; a_req_wdata = $urandom;
    for (int k = 1; k <= 12 && resp_k == 0; k++) begin
      @(negedge clk);
      if (a_mem_wren === 1'b1) begin wren_n++; wren_k = k; end
      if (k == 1) begin o_be = a_mem_be; o_wdata = a_mem_wdata; o_maddr = a_mem_addr; end
      if (a_resp_valid === 1'b1) begin resp_k = k; o_rdata = a_resp_rdata; o_fault = a_resp_fault; end
    end
    checks++;
    if (resp_k != exp_k) $display("FAIL resp_cycle f3=%b a=%h: got %0d expected %0d", f3, addr, resp_k, exp_k);
    else passed++;
    checks++;
    if (o_fault !== !legal) $display("FAIL resp_fault f3=%b a=%h: got %b expected %b", f3, addr, o_fault, !legal);
    else passed++;
    checks++;
    if (o_rdata !== exp_rdata) $display("FAIL resp_rdata f3=%b a=%h: got %h expected %h", f3, addr, o_rdata, exp_rdata);
    else passed++;
    checks++;
    if (wren_n != ((legal && we) ? 1 : 0)) $display("FAIL wren_count: got %0d expected %0d", wren_n, (legal && we) ? 1 : 0);
    else passed++;
    if (legal && we) begin
      checks++;
      if (wren_k != 1) $display("FAIL wren_cycle: got %0d expected 1", wren_k);
      else passed++;
      checks++;
      if (o_wdata !== ref_wdata(f3, wd)) $display("FAIL mem_wdata: got %h expected %h", o_wdata, ref_wdata(f3, wd));
      else passed++;
    end
    if (legal) begin
      checks++;
      if (o_maddr !== (addr & ~32'h3)) $display("FAIL mem_addr: got %h expected %h", o_maddr, addr & ~32'h3);
      else passed++;
      checks++;
      if (o_be !== ref_be(f3, addr)) $display("FAIL mem_be: got %b expected %b", o_be, ref_be(f3, addr));
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_resp_rdata !== o_rdata)
      $display("FAIL after_resp: got valid=%b ready=%b rdata=%h expected 0 1 %h",
               a_resp_valid, a_req_ready, a_resp_rdata, o_rdata);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({a_req_ready, a_resp_valid, a_resp_fault, a_mem_wren, a_mem_be, a_resp_rdata, a_mem_addr, a_mem_wdata} !== '0)
      $display("FAIL reset_outputs_a: got ready=%b valid=%b wren=%b be=%b addr=%h expected all 0",
               a_req_ready, a_resp_valid, a_mem_wren, a_mem_be, a_mem_addr);
    else passed++;
    checks++;
    if ({b_req_ready, b_resp_valid, b_resp_fault, b_mem_wren, b_mem_be, b_resp_rdata, b_mem_addr, b_mem_wdata} !== '0)
      $display("FAIL reset_outputs_b: got ready=%b valid=%b wren=%b expected all 0", b_req_ready, b_resp_valid, b_mem_wren);
    else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if (a_req_ready !== 1'b0) $display("FAIL ready_before_first_clock: got %b expected 0", a_req_ready);
    else passed++;
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1)
      $display("FAIL ready_after_release: got %b/%b expected 1/1", a_req_ready, b_req_ready);
    else passed++;
  endtask

  task automatic test_store_word();
    run_txn(1'b1, F3_W, 32'h1004, 32'hDEADBEEF, r_rdata, r_be, r_wdata, r_maddr, r_fault);
    checks++;
    if (r_maddr !== 32'h1004 || r_be !== 4'b1111 || r_wdata !== 32'hDEADBEEF || r_fault !== 1'b0 || r_rdata !== 32'h0)
      $display("FAIL sw_plan: got addr=%h be=%b wdata=%h fault=%b rdata=%h expected 00001004 1111 deadbeef 0 00000000",
               r_maddr, r_be, r_wdata, r_fault, r_rdata);
    else passed++;
  endtask

  task automatic test_store_lanes();
    run_txn(1'b1, F3_B, 32'h1003, 32'h000000A5, r_rdata, r_be, r_wdata, r_maddr, r_fault);
    checks++;
    if (r_maddr !== 32'h1000 || r_be !== 4'b1000 || r_wdata !== 32'hA5A5A5A5)
      $display("FAIL sb_plan: got addr=%h be=%b wdata=%h expected 00001000 1000 a5a5a5a5", r_maddr, r_be, r_wdata);
    else passed++;
    run_txn(1'b1, F3_H, 32'h1002, 32'h00001234, r_rdata, r_be, r_wdata, r_maddr, r_fault);
    checks++;
    if (r_be !== 4'b1100 || r_wdata !== 32'h12341234)
      $display("FAIL sh_plan: got be=%b wdata=%h expected 1100 12341234", r_be, r_wdata);
    else passed++;
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s  [3] = '{F3_B, F3_BU, F3_HU};
    logic [31:0] exps [3] = '{32'hFFFFFFF4, 32'h000000F4, 32'h000012F4};
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, f3s[i], 32'h1002, 32'h0, r_rdata, r_be, r_wdata, r_maddr, r_fault);
      checks++;
      if (r_rdata !== exps[i]) $display("FAIL load_ext_%0d: got %h expected %h", i, r_rdata, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_faults();
    run_txn(1'b0, F3_W, 32'h1001, 32'h0, r_rdata, r_be, r_wdata, r_maddr, r_fault);
    checks++;
    if (r_fault !== 1'b1 || r_rdata !== 32'h0) $display("FAIL lw_misaligned: got fault=%b rdata=%h expected 1 0", r_fault, r_rdata);
    else passed++;
    run_txn(1'b1, 3'b100, 32'h1000, 32'h55AA55AA, r_rdata, r_be, r_wdata, r_maddr, r_fault);
    checks++;
    if (r_fault !== 1'b1 || r_rdata !== 32'h0) $display("FAIL store_f3_100: got fault=%b rdata=%h expected 1 0", r_fault, r_rdata);
    else passed++;
  endtask

  task automatic test_latency3();
    logic [31:0] exp;
    exp = mem_word(32'h2000);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = F3_W; b_req_addr = 32'h2000; b_req_wdata = $urandom;
    checks++;
    if (b_req_ready !== 1'b1) $display("FAIL lat3_ready_n: got %b expected 1", b_req_ready);
    else passed++;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 7) b_req_valid = 1'b0;
      if ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) begin
        checks++;
        if (b_mem_addr !== 32'h2000) $display("FAIL lat3_addr_k%0d: got %h expected 00002000", k, b_mem_addr);
        else passed++;
      end
      checks++;
      if (b_resp_valid !== (k == 5 || k == 11)) $display("FAIL lat3_valid_k%0d: got %b expected %b", k, b_resp_valid, k == 5 || k == 11);
      else passed++;
      checks++;
      if (b_req_ready !== (k == 6 || k == 12)) $display("FAIL lat3_ready_k%0d: got %b expected %b", k, b_req_ready, k == 6 || k == 12);
      else passed++;
      checks++;
      if (b_mem_wren !== 1'b0) $display("FAIL lat3_wren_k%0d: got %b expected 0", k, b_mem_wren);
      else passed++;
      if (k == 5 || k == 11) begin
        checks++;
        if (b_resp_rdata !== exp || b_resp_fault !== 1'b0)
          $display("FAIL lat3_rdata_k%0d: got %h fault=%b expected %h 0", k, b_resp_rdata, b_resp_fault, exp);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_funct3 = F3_W; a_req_addr = 32'h1008;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_mem_addr !== 32'h1008) $display("FAIL wait_addr: got %h expected 00001008", a_mem_addr);
    else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if ({a_resp_valid, a_mem_wren, a_req_ready, a_mem_be, a_mem_addr, a_resp_rdata} !== '0)
      $display("FAIL reset_in_wait: got valid=%b wren=%b ready=%b addr=%h expected all 0",
               a_resp_valid, a_mem_wren, a_req_ready, a_mem_addr);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1)
        $display("FAIL post_reset_wait_k%0d: got valid=%b ready=%b expected 0 1", k, a_resp_valid, a_req_ready);
      else passed++;
    end
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_funct3 = F3_W; a_req_addr = 32'h100C; a_req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_mem_wren !== 1'b1) $display("FAIL issue_wren: got %b expected 1", a_mem_wren);
    else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if ({a_resp_valid, a_mem_wren, a_mem_be, a_mem_wdata, a_mem_addr} !== '0)
      $display("FAIL reset_in_issue: got valid=%b wren=%b be=%b wdata=%h expected all 0",
               a_resp_valid, a_mem_wren, a_mem_be, a_mem_wdata);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (a_resp_valid !== 1'b0 || a_mem_wren !== 1'b0)
        $display("FAIL post_reset_issue_k%0d: got valid=%b wren=%b expected 0 0", k, a_resp_valid, a_mem_wren);
      else passed++;
    end
    run_txn(1'b1, F3_W, 32'h1010, 32'h0BADCAFE, r_rdata, r_be, r_wdata, r_maddr, r_fault);
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    for (int i = 0; i < 60; i++) begin
      we   = 1'($urandom % 2);
      f3   = 3'($urandom % 8);
      addr = 32'h1000 + ($urandom % 64);
      wd   = $urandom;
      run_txn(we, f3, addr, wd, r_rdata, r_be, r_wdata, r_maddr, r_fault);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_funct3 = 3'b000; a_req_addr = 32'h0; a_req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'b000; b_req_addr = 32'h0; b_req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    test_store_word();
    test_store_lanes();
    test_load_extend();
    test_faults();
    test_latency3();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
